// File: rtl/speech_pkg.sv
// -----------------------------------------------------------------------------
// speech_pkg
// Shared constants for the speech sequencer: controller state encoding,
// default end-of-message byte and the PicoBlaze port-id map.
// -----------------------------------------------------------------------------
package speech_pkg;

    // Controller state encoding (3-bit, legacy-compatible constants).
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_PUSH      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_RELEASE   = 3'd5;

    // Phoneme value that terminates a message.
    localparam logic [7:0] EOM_BYTE_DEFAULT = 8'h00;

    // PicoBlaze port ids used by the wrapper around the sequencer.
    localparam logic [7:0] PORT_ID_DATA    = 8'h00;
    localparam logic [7:0] PORT_ID_START   = 8'h20;
    localparam logic [7:0] PORT_ID_ACK     = 8'h40;
    localparam logic [7:0] PORT_ID_STATUS  = 8'h80;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read and an occupancy count.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   push, push_data : write request/data; ignored while full
//   pop             : read request; ignored while empty
//   head_data       : current head entry (don't-care while empty)
//   empty, full     : status flags
//   count           : occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Fullness is judged on the current count only, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pico_phoneme_controller.sv
// -----------------------------------------------------------------------------
// pico_phoneme_controller
// Requests phonemes from the PicoBlaze speech sequencer, captures each byte on
// the rising edge of pico_done, buffers it for the sample player and
// acknowledges the PicoBlaze. An end-of-message byte ends the message.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   enable                 : keep requesting phonemes while high
//   start_pico             : request-next-phoneme level to the PicoBlaze
//   pico_done, pico_data   : PicoBlaze strobe (level) and phoneme byte
//   address_ready_for_pico : one-cycle acknowledge to the PicoBlaze
//   phoneme_valid/ready    : player handshake; a pop happens on any cycle where
//                            both are high, phoneme_data is the show-ahead head
//                            and stays stable until that pop
//   fifo_count             : buffer occupancy
//   msg_done               : one-cycle pulse on the end-of-message byte
//   timeout_err            : sticky flag, PicoBlaze did not answer in time
//   state_dbg              : current controller state
// -----------------------------------------------------------------------------
module pico_phoneme_controller
    import speech_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] EOM_BYTE       = EOM_BYTE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    output logic                          start_pico,
    input  logic                          pico_done,
    input  logic [7:0]                    pico_data,
    output logic                          address_ready_for_pico,
    output logic                          phoneme_valid,
    output logic [7:0]                    phoneme_data,
    input  logic                          phoneme_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          msg_done,
    output logic                          timeout_err,
    output logic [2:0]                    state_dbg
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int             TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q,       state_d;
    logic             done_q,        done_d;
    logic [7:0]       byte_q,        byte_d;
    logic             start_pico_q,  start_pico_d;
    logic             ack_q,         ack_d;
    logic             msg_done_q,    msg_done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             last_eom_q,    last_eom_d;
    logic [TMO_W-1:0] tmo_cnt_q,     tmo_cnt_d;

    logic done_rise;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_empty;
    logic fifo_full;

    assign done_rise = pico_done & ~done_q;
    assign fifo_pop  = phoneme_ready & ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (byte_q),
        .pop       (fifo_pop),
        .head_data (phoneme_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        done_d        = pico_done;
        byte_d        = byte_q;
        start_pico_d  = start_pico_q;
        ack_d         = 1'b0;
        msg_done_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        last_eom_d    = last_eom_q;
        tmo_cnt_d     = tmo_cnt_q;
        fifo_push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_pico_d = 1'b1;
                tmo_cnt_d    = '0;
                state_d      = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A strobe arriving on the last counted cycle still wins.
                if (done_rise) begin
                    byte_d       = pico_data;
                    start_pico_d = 1'b0;
                    state_d      = ST_PUSH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    start_pico_d  = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_PUSH: begin
                if (byte_q == EOM_BYTE) begin
                    msg_done_d = 1'b1;
                    last_eom_d = 1'b1;
                    state_d    = ST_ACK;
                end else if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    last_eom_d = 1'b0;
                    state_d    = ST_ACK;
                end
                // Full FIFO: byte_q is held and the push retried every cycle.
            end
            ST_ACK: begin
                ack_d   = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Wait for the strobe to drop so a long strobe is captured once.
                if (!pico_done) begin
                    state_d = (enable && !last_eom_q) ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                start_pico_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            byte_q        <= 8'h00;
            start_pico_q  <= 1'b0;
            ack_q         <= 1'b0;
            msg_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            last_eom_q    <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            byte_q        <= byte_d;
            start_pico_q  <= start_pico_d;
            ack_q         <= ack_d;
            msg_done_q    <= msg_done_d;
            timeout_err_q <= timeout_err_d;
            last_eom_q    <= last_eom_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign start_pico             = start_pico_q;
    assign address_ready_for_pico = ack_q;
    assign msg_done               = msg_done_q;
    assign timeout_err            = timeout_err_q;
    assign phoneme_valid          = ~fifo_empty;
    assign state_dbg              = state_q;

endmodule
